// File: rtl/pc_counter_pkg.sv
// rtl/pc_counter_pkg.sv - shared PC width and address type for the fetch front end
package pc_counter_pkg;

    localparam int unsigned PC_WIDTH = 32;

    typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - program-counter register with sequential increment, redirect and stall
module pc_counter
    import pc_counter_pkg::*;
#(
    parameter int unsigned PC_WIDTH     = 32,
    parameter pc_t         PC_INC       = pc_t'(1),
    parameter pc_t         PC_RESET_VAL = pc_t'(0)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic pc_override,
    input  pc_t  pc_in,
    output pc_t  current_pc,
    output pc_t  next_pc
);

    generate
        if (PC_WIDTH != $bits(pc_t)) begin : g_bad_width
            $error("pc_counter: PC_WIDTH must match the package pc_t width");
        end
        if (PC_INC == pc_t'(0)) begin : g_bad_inc
            $error("pc_counter: PC_INC must be greater than zero");
        end
    endgenerate

    pc_t pc_q;
    pc_t pc_d;

    // A redirect is not latched: if en is low, the override is simply dropped.
    always_comb begin
        pc_d = pc_q + PC_INC;
        if (pc_override) begin
            pc_d = pc_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= PC_RESET_VAL;
        end else if (en) begin
            pc_q <= pc_d;
        end
    end

    assign current_pc = pc_q;
    assign next_pc    = pc_d;

endmodule

// File: tb/tb_pc_counter.sv
// tb/tb_pc_counter.sv - randomized self-checking bench for pc_counter against a reference model
module tb_pc_counter;
    import pc_counter_pkg::*;

    logic clk;
    logic rst;
    logic en;
    logic pc_override;
    pc_t  pc_in;
    pc_t  current_pc;
    pc_t  next_pc;

    int checks;
    int failures;

    // Reference state: the address the fetch unit should be holding.
    pc_t exp_pc;

    pc_counter dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pc_override (pc_override),
        .pc_in       (pc_in),
        .current_pc  (current_pc),
        .next_pc     (next_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input pc_t got, input pc_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs mid-low-phase, check the combinational and register
    // values before the edge, then check the register after the edge.
    task automatic step(input logic e, input logic o, input pc_t p, input logic r);
        pc_t exp_next;
        @(negedge clk);
        en          = e;
        pc_override = o;
        pc_in       = p;
        rst         = r;
        if (r) exp_pc = 32'd0;
        exp_next = o ? p : exp_pc + 32'd1;
        #1;
        check_val("cur_pre_edge", current_pc, exp_pc);
        check_val("next_pc", next_pc, exp_next);
        @(posedge clk);
        if (!r && e) exp_pc = exp_next;
        #1;
        check_val("cur_post_edge", current_pc, exp_pc);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        en          = 1'b1;
        pc_override = 1'b0;
        pc_in       = '0;
        exp_pc      = '0;

        #1;
        check_val("reset_cur", current_pc, 32'd0);
        check_val("reset_next", next_pc, 32'd1);

        // Power-up: reset held with en high.
        repeat (2) step(1'b1, 1'b0, '0, 1'b1);

        // Count 0..10.
        repeat (10) step(1'b1, 1'b0, '0, 1'b0);
        check_val("count_to_10", current_pc, 32'd10);

        // Redirect to 15 then continue.
        step(1'b1, 1'b1, 32'd15, 1'b0);
        check_val("redirect_15", current_pc, 32'd15);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        check_val("after_redirect", current_pc, 32'd17);

        // Mid-count asynchronous reset for 3 cycles, then restart from 0.
        repeat (3) step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        check_val("restart_from_0", current_pc, 32'd1);

        // Stall at 3, with and without override.
        repeat (2) step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 32'h1234, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        check_val("stall_hold_3", current_pc, 32'd3);
        step(1'b1, 1'b0, '0, 1'b0);
        check_val("resume_4", current_pc, 32'd4);

        // Wrap-around.
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        check_val("wrap_to_0", current_pc, 32'd0);

        // Simultaneous reset and override: reset wins.
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        check_val("rst_beats_ovr", current_pc, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic e, o, r;
            pc_t  p;
            e = ($urandom_range(0, 3) != 0);
            o = ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 29) == 0);
            p = (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + pc_t'($urandom_range(0, 15))
                                              : pc_t'($urandom));
            step(e, o, p, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
